// File: rtl/ql_dsp_mac_pipe_if.sv
// ---------------------------------------------------------------------------
// ql_dsp_mac_pipe_if
//
// Operand / control / result bundle of the pipelined DSP multiply-accumulate
// block. The fabric side drives the operands and per-op controls through the
// master modport; the MAC itself attaches through the slave modport.
//
// Signals:
//   valid_i          qualifies a_i, b_i and every per-op control below
//   a_i, b_i         multiplicand / multiplier
//   unsigned_a/b     1 = operand is unsigned, 0 = two's complement
//   load_acc         1 = add product to accumulator, 0 = start a new sum
//   subtract         1 = negate the product first
//   shift_right      arithmetic right shift applied to the accumulator view
//   round            round half-up before the shift
//   saturate_enable  clamp the result to the signed OUT_W range
//   z_o, valid_o     result and its qualifier
//   overflow_o       sticky signed accumulator overflow
//   dly_b_o          last accepted b_i, for cascading into a neighbour
// ---------------------------------------------------------------------------
interface ql_dsp_mac_pipe_if #(
    parameter int A_W     = 20,
    parameter int B_W     = 18,
    parameter int OUT_W   = 38,
    parameter int SHIFT_W = 6
);
    logic               valid_i;
    logic [A_W-1:0]     a_i;
    logic [B_W-1:0]     b_i;
    logic               unsigned_a;
    logic               unsigned_b;
    logic               load_acc;
    logic               subtract;
    logic [SHIFT_W-1:0] shift_right;
    logic               round;
    logic               saturate_enable;
    logic [OUT_W-1:0]   z_o;
    logic               valid_o;
    logic               overflow_o;
    logic [B_W-1:0]     dly_b_o;

    modport master (
        output valid_i, a_i, b_i, unsigned_a, unsigned_b, load_acc, subtract,
               shift_right, round, saturate_enable,
        input  z_o, valid_o, overflow_o, dly_b_o
    );

    modport slave (
        input  valid_i, a_i, b_i, unsigned_a, unsigned_b, load_acc, subtract,
               shift_right, round, saturate_enable,
        output z_o, valid_o, overflow_o, dly_b_o
    );
endinterface

// File: rtl/ql_dsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// ql_dsp_mac_pipe
//
// Parametrised pipelined multiply-accumulate block for the DSP tile.
// Pipeline: optional input register (PIPE_IN=1) -> multiply/accumulate
// stage (acc register) -> output stage (round, shift, saturate, z register).
// One op per clock, no stalls; back-to-back accumulates see the acc value
// written on the previous clock because the acc register feeds itself.
//
// Ports:
//   clock          rising-edge block clock
//   global_resetn  asynchronous active-low reset, clears every register
//   reset          synchronous clear of acc, flags, valids, z_o and dly_b_o;
//                  wins over valid_i and discards in-flight ops
//   bus            ql_dsp_mac_pipe_if.slave operand/control/result bundle
//   scan_en/scan_i/scan_o
//                  only when QL_DSP_MAC_SCAN_EN is defined: serial shift
//                  access to the accumulator, pipeline frozen meanwhile
//
// Optional feature macro: QL_DSP_MAC_SCAN_EN (undefined by default; the
// scan ports and the acc scan mux then do not exist).
// ---------------------------------------------------------------------------
module ql_dsp_mac_pipe #(
    parameter int A_W     = 20,
    parameter int B_W     = 18,
    parameter int ACC_W   = 44,
    parameter int OUT_W   = 38,
    parameter int SHIFT_W = 6,
    parameter int PIPE_IN = 1
) (
    input  logic clock,
    input  logic global_resetn,
    input  logic reset,
`ifdef QL_DSP_MAC_SCAN_EN
    input  logic scan_en,
    input  logic scan_i,
    output logic scan_o,
`endif
    ql_dsp_mac_pipe_if.slave bus
);

    // Full product width: big enough for unsigned x unsigned and for the
    // negation of that product.
    localparam int P_W = A_W + B_W + 1;

    localparam logic [31:0]    SHIFT_MAX = 32'(ACC_W - 1);
    localparam logic [ACC_W:0] RND_ONE   = (ACC_W + 1)'(1);
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    // run = 0 freezes every pipeline register (scan mode only).
    logic run;

`ifdef QL_DSP_MAC_SCAN_EN
    assign run = ~scan_en;
`else
    assign run = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Operands and controls presented to the multiply/accumulate stage
    // ------------------------------------------------------------------
    logic               mul_valid;
    logic [A_W-1:0]     mul_a;
    logic [B_W-1:0]     mul_b;
    logic               mul_ua;
    logic               mul_ub;
    logic               mul_load;
    logic               mul_sub;
    logic [SHIFT_W-1:0] mul_shift;
    logic               mul_round;
    logic               mul_sat;

    generate
        if (PIPE_IN != 0) begin : g_in_reg
            // Input register: operands are only captured on valid ops so
            // idle cycles leave the last op's values in place.
            always_ff @(posedge clock or negedge global_resetn) begin
                if (!global_resetn) begin
                    mul_valid <= 1'b0;
                    mul_a     <= '0;
                    mul_b     <= '0;
                    mul_ua    <= 1'b0;
                    mul_ub    <= 1'b0;
                    mul_load  <= 1'b0;
                    mul_sub   <= 1'b0;
                    mul_shift <= '0;
                    mul_round <= 1'b0;
                    mul_sat   <= 1'b0;
                end else if (reset) begin
                    mul_valid <= 1'b0;
                end else if (run) begin
                    mul_valid <= bus.valid_i;
                    if (bus.valid_i) begin
                        mul_a     <= bus.a_i;
                        mul_b     <= bus.b_i;
                        mul_ua    <= bus.unsigned_a;
                        mul_ub    <= bus.unsigned_b;
                        mul_load  <= bus.load_acc;
                        mul_sub   <= bus.subtract;
                        mul_shift <= bus.shift_right;
                        mul_round <= bus.round;
                        mul_sat   <= bus.saturate_enable;
                    end
                end
            end
        end else begin : g_in_comb
            assign mul_valid = bus.valid_i;
            assign mul_a     = bus.a_i;
            assign mul_b     = bus.b_i;
            assign mul_ua    = bus.unsigned_a;
            assign mul_ub    = bus.unsigned_b;
            assign mul_load  = bus.load_acc;
            assign mul_sub   = bus.subtract;
            assign mul_shift = bus.shift_right;
            assign mul_round = bus.round;
            assign mul_sat   = bus.saturate_enable;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Multiply / accumulate datapath
    // ------------------------------------------------------------------
    logic signed [A_W:0]       a_ext;
    logic signed [B_W:0]       b_ext;
    logic signed [P_W-1:0]     a_wide;
    logic signed [P_W-1:0]     b_wide;
    logic signed [P_W-1:0]     prod;
    logic signed [P_W-1:0]     prod_sgn;
    logic signed [ACC_W-1:0]   p_acc;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      add_ovf;
    logic                      overflow;
    logic                      ovf_next;

    // Operands are widened to the full product width before multiplying
    // so the low P_W bits of the product are exact for every sign mix.
    always_comb begin
        a_ext    = {~mul_ua & mul_a[A_W-1], mul_a};
        b_ext    = {~mul_ub & mul_b[B_W-1], mul_b};
        a_wide   = P_W'(a_ext);
        b_wide   = P_W'(b_ext);
        prod     = a_wide * b_wide;
        prod_sgn = mul_sub ? -prod : prod;
        p_acc    = ACC_W'(prod_sgn);
        acc_base = mul_load ? acc : '0;
        acc_next = acc_base + p_acc;
        add_ovf  = (acc_base[ACC_W-1] == p_acc[ACC_W-1]) &&
                   (acc_next[ACC_W-1] != p_acc[ACC_W-1]);
        // A fresh sum clears the sticky flag unless the op itself overflows.
        ovf_next = (mul_load & overflow) | add_ovf;
    end

    // Accumulator and sticky overflow; in scan builds the acc doubles as a
    // shift register while scan_en is high.
    always_ff @(posedge clock or negedge global_resetn) begin
        if (!global_resetn) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (reset) begin
            acc      <= '0;
            overflow <= 1'b0;
`ifdef QL_DSP_MAC_SCAN_EN
        end else if (scan_en) begin
            acc      <= {scan_i, acc[ACC_W-1:1]};
`endif
        end else if (mul_valid) begin
            acc      <= acc_next;
            overflow <= ovf_next;
        end
    end

`ifdef QL_DSP_MAC_SCAN_EN
    assign scan_o = acc[0];
`endif

    // ------------------------------------------------------------------
    // Output-stage controls travel alongside the acc update so the shift,
    // round and saturate settings belong to the same op as the acc value.
    // ------------------------------------------------------------------
    logic               fin_valid;
    logic [SHIFT_W-1:0] fin_shift;
    logic               fin_round;
    logic               fin_sat;

    always_ff @(posedge clock or negedge global_resetn) begin
        if (!global_resetn) begin
            fin_valid <= 1'b0;
            fin_shift <= '0;
            fin_round <= 1'b0;
            fin_sat   <= 1'b0;
        end else if (reset) begin
            fin_valid <= 1'b0;
        end else if (run) begin
            fin_valid <= mul_valid;
            if (mul_valid) begin
                fin_shift <= mul_shift;
                fin_round <= mul_round;
                fin_sat   <= mul_sat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round, shift and saturate
    // ------------------------------------------------------------------
    logic [31:0]             fin_amt;
    logic [ACC_W:0]          rnd_sum;
    logic signed [ACC_W:0]   fin_shifted;
    logic [ACC_W-OUT_W+1:0]  fin_upper;
    logic                    in_range;
    logic [OUT_W-1:0]        z_next;

    // Rounding is done one bit wider than the acc so adding the half-LSB
    // to the most positive acc value cannot wrap.
    always_comb begin
        fin_amt = 32'(fin_shift);
        if (fin_amt > SHIFT_MAX) begin
            fin_amt = SHIFT_MAX;
        end
        rnd_sum = {acc[ACC_W-1], acc};
        if (fin_round && (fin_amt != 32'd0)) begin
            rnd_sum = rnd_sum + (RND_ONE << (fin_amt - 32'd1));
        end
        fin_shifted = $signed(rnd_sum) >>> fin_amt;
        // Value fits in OUT_W signed bits when every bit from the OUT_W sign
        // position upward agrees.
        fin_upper = fin_shifted[ACC_W:OUT_W-1];
        in_range  = (&fin_upper) | ~(|fin_upper);
        z_next    = fin_shifted[OUT_W-1:0];
        if (fin_sat && !in_range) begin
            z_next = fin_shifted[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

    // Result register: z holds between valid results.
    logic [OUT_W-1:0] res_z;
    logic             res_valid;

    always_ff @(posedge clock or negedge global_resetn) begin
        if (!global_resetn) begin
            res_z     <= '0;
            res_valid <= 1'b0;
        end else if (reset) begin
            res_z     <= '0;
            res_valid <= 1'b0;
        end else if (run) begin
            res_valid <= fin_valid;
            if (fin_valid) begin
                res_z <= z_next;
            end
        end
    end

    // Cascade output: b of the most recently accepted op.
    logic [B_W-1:0] dly_b;

    always_ff @(posedge clock or negedge global_resetn) begin
        if (!global_resetn) begin
            dly_b <= '0;
        end else if (reset) begin
            dly_b <= '0;
        end else if (run && bus.valid_i) begin
            dly_b <= bus.b_i;
        end
    end

    assign bus.z_o        = res_z;
    assign bus.valid_o    = res_valid & run;
    assign bus.overflow_o = overflow;
    assign bus.dly_b_o    = dly_b;

endmodule

// File: tb/tb_ql_dsp_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_ql_dsp_mac_pipe
//
// Self-checking bench for ql_dsp_mac_pipe with default parameters and
// PIPE_IN=1. A table of single ops with hand-computed results is applied in
// order (the acc carries over between entries), followed by hand-written
// sequences for back-to-back accumulation, overflow, synchronous reset
// collision and asynchronous reset mid-stream.
// ---------------------------------------------------------------------------
module tb_ql_dsp_mac_pipe;

    localparam int A_W     = 20;
    localparam int B_W     = 18;
    localparam int ACC_W   = 44;
    localparam int OUT_W   = 38;
    localparam int SHIFT_W = 6;

    logic clock = 1'b0;
    logic global_resetn;
    logic reset;

    int total  = 0;
    int passed = 0;

    ql_dsp_mac_pipe_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) bus ();

    ql_dsp_mac_pipe #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .SHIFT_W(SHIFT_W), .PIPE_IN(1)
    ) dut (
        .clock(clock),
        .global_resetn(global_resetn),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [A_W-1:0]     a;
        logic [B_W-1:0]     b;
        logic               ua;
        logic               ub;
        logic               load;
        logic               sub;
        logic [SHIFT_W-1:0] shift;
        logic               rnd;
        logic               sat;
        logic [OUT_W-1:0]   z;
        logic               ovf;
    } vec_t;

    function automatic vec_t mk(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                input logic ua, input logic ub, input logic load,
                                input logic sub, input logic [SHIFT_W-1:0] shift,
                                input logic rnd, input logic sat,
                                input logic [OUT_W-1:0] z, input logic ovf);
        vec_t v;
        v.a = a; v.b = b; v.ua = ua; v.ub = ub; v.load = load; v.sub = sub;
        v.shift = shift; v.rnd = rnd; v.sat = sat; v.z = z; v.ovf = ovf;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        bus.a_i             = v.a;
        bus.b_i             = v.b;
        bus.unsigned_a      = v.ua;
        bus.unsigned_b      = v.ub;
        bus.load_acc        = v.load;
        bus.subtract        = v.sub;
        bus.shift_right     = v.shift;
        bus.round           = v.rnd;
        bus.saturate_enable = v.sat;
        bus.valid_i         = 1'b1;
    endtask

    // Issues one op and waits (bounded) for its result. lat counts clock
    // edges from the sampling edge to the edge that raised valid_o.
    task automatic apply_stimulus(input vec_t v, output logic [OUT_W-1:0] z,
                                  output logic ovf, output logic [B_W-1:0] dly_b,
                                  output int lat);
        @(negedge clock);
        drive_op(v);
        @(negedge clock);
        bus.valid_i = 1'b0;
        dly_b = bus.dly_b_o;
        lat = 1;
        while (bus.valid_o !== 1'b1 && lat < 12) begin
            @(negedge clock);
            lat++;
        end
        z   = bus.z_o;
        ovf = bus.overflow_o;
    endtask

    // Runs one op and checks value, flag, cascade output and latency.
    task automatic run_and_check(input string tag, input vec_t v);
        logic [OUT_W-1:0] z;
        logic             ovf;
        logic [B_W-1:0]   db;
        int               lat;
        apply_stimulus(v, z, ovf, db, lat);
        check_output({tag, " latency"}, 64'(lat), 64'd3);
        check_output({tag, " z"}, 64'(z), 64'(v.z));
        check_output({tag, " ovf"}, 64'(ovf), 64'(v.ovf));
        check_output({tag, " dly_b"}, 64'(db), 64'(v.b));
    endtask

    localparam logic [A_W-1:0]   A_MAXU  = 20'hFFFFF;
    localparam logic [B_W-1:0]   B_MAXU  = 18'h3FFFF;
    localparam logic [OUT_W-1:0] Z_SMAX  = 38'h1F_FFFF_FFFF;
    localparam logic [OUT_W-1:0] Z_SMIN  = 38'h20_0000_0000;
    localparam logic [OUT_W-1:0] Z_PLOW  = 38'h3F_FFEC_0001;

    vec_t vecs[19];

    initial begin
        logic [OUT_W-1:0] z;
        logic             ovf;
        logic [B_W-1:0]   db;
        int               lat;
        int               n;
        logic             seen;

        // Expected results assume the acc carries over from entry to entry.
        vecs[0]  = mk(20'd3,    18'd5,    1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 38'd15, 1'b0);
        vecs[1]  = mk(-20'sd2,  18'd7,    1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 38'd1, 1'b0);
        vecs[2]  = mk(20'd10,   18'd10,   1'b0, 1'b0, 1'b0, 1'b1, 6'd0,  1'b0, 1'b0, -38'sd100, 1'b0);
        vecs[3]  = mk(20'd7,    18'd1,    1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  1'b1, 1'b0, 38'd4, 1'b0);
        vecs[4]  = mk(20'd0,    18'd0,    1'b0, 1'b0, 1'b1, 1'b0, 6'd1,  1'b0, 1'b0, 38'd3, 1'b0);
        vecs[5]  = mk(-20'sd7,  18'd1,    1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  1'b1, 1'b0, -38'sd3, 1'b0);
        vecs[6]  = mk(20'd0,    18'd0,    1'b0, 1'b0, 1'b1, 1'b0, 6'd1,  1'b0, 1'b0, -38'sd4, 1'b0);
        vecs[7]  = mk(20'd5,    18'd1,    1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 38'd5, 1'b0);
        // shift 63 clamps to 43; (-1 + 2^42) >>> 43 = 0
        vecs[8]  = mk(-20'sd1,  18'd1,    1'b0, 1'b0, 1'b0, 1'b0, 6'd63, 1'b1, 1'b0, 38'd0, 1'b0);
        vecs[9]  = mk(20'd0,    18'd0,    1'b0, 1'b0, 1'b1, 1'b0, 6'd43, 1'b0, 1'b0, -38'sd1, 1'b0);
        vecs[10] = mk(-20'sd3,  -18'sd4,  1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 38'd12, 1'b0);
        vecs[11] = mk(-20'sd3,  18'd1,    1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 38'd1048573, 1'b0);
        vecs[12] = mk(20'd2,    B_MAXU,   1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 38'd524286, 1'b0);
        vecs[13] = mk(A_MAXU,   B_MAXU,   1'b1, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, Z_SMAX, 1'b0);
        vecs[14] = mk(20'd0,    18'd0,    1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, Z_PLOW, 1'b0);
        vecs[15] = mk(A_MAXU,   B_MAXU,   1'b1, 1'b1, 1'b0, 1'b1, 6'd0,  1'b0, 1'b1, Z_SMIN, 1'b0);
        vecs[16] = mk(20'd4,    18'd4,    1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 38'd16, 1'b0);
        vecs[17] = mk(20'd2,    18'd3,    1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 38'd10, 1'b0);
        vecs[18] = mk(-20'sd1,  -18'sd1,  1'b0, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 1'b0, 38'd11, 1'b0);

        global_resetn = 1'b0;
        reset         = 1'b0;
        drive_op(mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0));
        bus.valid_i   = 1'b0;

        // Reset state
        #12;
        check_output("reset z", 64'(bus.z_o), 64'd0);
        check_output("reset valid", 64'(bus.valid_o), 64'd0);
        check_output("reset ovf", 64'(bus.overflow_o), 64'd0);
        check_output("reset dly_b", 64'(bus.dly_b_o), 64'd0);
        @(negedge clock);
        global_resetn = 1'b1;

        // Directed table
        for (int i = 0; i < 19; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i]);
        end

        // Back-to-back accumulate: 3*5 then +(-2*7) on consecutive clocks
        @(negedge clock);
        drive_op(mk(20'd3, 18'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0));
        @(negedge clock);
        drive_op(mk(-20'sd2, 18'd7, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0));
        @(negedge clock);
        bus.valid_i = 1'b0;
        n = 0;
        while (bus.valid_o !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_output("b2b first latency", 64'(n), 64'd1);
        check_output("b2b first z", 64'(bus.z_o), 64'd15);
        @(negedge clock);
        check_output("b2b second valid", 64'(bus.valid_o), 64'd1);
        check_output("b2b second z", 64'(bus.z_o), 64'd1);
        @(negedge clock);
        check_output("b2b idle valid", 64'(bus.valid_o), 64'd0);

        // Overflow: 33 * ((2^20-1)*(2^18-1)) exceeds the 44-bit signed range
        apply_stimulus(mk(A_MAXU, B_MAXU, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0),
                       z, ovf, db, lat);
        for (int k = 0; k < 31; k++) begin
            apply_stimulus(mk(A_MAXU, B_MAXU, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0),
                           z, ovf, db, lat);
        end
        check_output("ovf before wrap", 64'(ovf), 64'd0);
        check_output("ovf acc 32P sat-off z", 64'(z), 64'(38'h3F_FD80_0020));
        apply_stimulus(mk(A_MAXU, B_MAXU, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, '0, 1'b0),
                       z, ovf, db, lat);
        check_output("ovf on wrap", 64'(ovf), 64'd1);
        check_output("ovf wrapped sat z", 64'(z), 64'(Z_SMIN));
        apply_stimulus(mk(20'd0, 18'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0),
                       z, ovf, db, lat);
        check_output("ovf sticky", 64'(ovf), 64'd1);
        apply_stimulus(mk(20'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0),
                       z, ovf, db, lat);
        check_output("ovf cleared by load", 64'(ovf), 64'd0);
        check_output("ovf load z", 64'(z), 64'd1);

        // Synchronous reset collides with a valid op while two are in flight
        @(negedge clock);
        drive_op(mk(20'd100, 18'd100, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0));
        @(negedge clock);
        drive_op(mk(20'd5, 18'd5, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0));
        @(negedge clock);
        drive_op(mk(20'd9, 18'd9, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, '0, 1'b0));
        reset = 1'b1;
        @(negedge clock);
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        check_output("sreset valid", 64'(bus.valid_o), 64'd0);
        check_output("sreset z", 64'(bus.z_o), 64'd0);
        check_output("sreset dly_b", 64'(bus.dly_b_o), 64'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (bus.valid_o === 1'b1) seen = 1'b1;
        end
        check_output("sreset discarded ops", 64'(seen), 64'd0);
        // Accumulating onto a cleared acc must return the bare product.
        run_and_check("sreset acc", mk(20'd6, 18'd7, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 38'd42, 1'b0));

        // Asynchronous reset in the middle of a random stream
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            bus.a_i             = A_W'($urandom);
            bus.b_i             = B_W'($urandom);
            bus.unsigned_a      = 1'($urandom);
            bus.unsigned_b      = 1'($urandom);
            bus.load_acc        = 1'($urandom);
            bus.subtract        = 1'($urandom);
            bus.shift_right     = SHIFT_W'($urandom_range(0, 8));
            bus.round           = 1'($urandom);
            bus.saturate_enable = 1'($urandom);
            bus.valid_i         = 1'b1;
        end
        #2;
        global_resetn = 1'b0;
        #1;
        check_output("areset z", 64'(bus.z_o), 64'd0);
        check_output("areset valid", 64'(bus.valid_o), 64'd0);
        check_output("areset ovf", 64'(bus.overflow_o), 64'd0);
        check_output("areset dly_b", 64'(bus.dly_b_o), 64'd0);
        @(negedge clock);
        bus.valid_i = 1'b0;
        @(negedge clock);
        global_resetn = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (bus.valid_o === 1'b1) seen = 1'b1;
        end
        check_output("areset no partial", 64'(seen), 64'd0);
        run_and_check("areset first op", mk(20'd3, 18'd5, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 38'd15, 1'b0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the bench always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
